// File: rtl/vlsu_pkg.sv
// Shared definitions for the vector load/store unit: default geometry and
// the control FSM state encoding.
package vlsu_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int VLEN_DEF       = 128;
    localparam int ELEN_DEF       = 32;
    localparam int NLANES_DEF     = 4;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/vlsu_addr_gen.sv
// Per-lane element address and enable generation. The address wraps modulo
// 2^XLEN and only its low ADDR_WIDTH bits reach the memory lane.
module vlsu_addr_gen
    import vlsu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ELEN       = ELEN_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int VLW        = 3
) (
    input  logic [XLEN-1:0]       base,
    input  logic [XLEN-1:0]       stride,
    input  logic                  strided,
    input  logic [XLEN-1:0]       elem,
    input  logic [VLW-1:0]        vl_eff,
    input  logic                  mask_bit,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  enable
);

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] full_addr;

    // Unit-stride steps by one element's byte size; strided uses the signed stride.
    assign step      = strided ? stride : XLEN'(ELEN / 8);
    assign full_addr = base + elem * step;
    assign addr      = full_addr[ADDR_WIDTH-1:0];
    assign enable    = (elem < XLEN'(vl_eff)) && mask_bit;

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: accepts one vector request, issues it to NLANES
// memory lanes over ceil(vl_eff/NLANES) beats, gathers load data, and
// holds a single response until it is consumed.
module vector_lsu
    import vlsu_pkg::*;
#(
    parameter int  XLEN       = XLEN_DEF,
    parameter int  VLEN       = VLEN_DEF,
    parameter int  ELEN       = ELEN_DEF,
    parameter int  NLANES     = NLANES_DEF,
    parameter int  ADDR_WIDTH = ADDR_WIDTH_DEF,
    localparam int NELEM      = VLEN / ELEN,
    localparam int VLW        = $clog2(NELEM) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_store,
    input  logic                         req_strided,
    input  logic [XLEN-1:0]              req_base,
    input  logic [XLEN-1:0]              req_stride,
    input  logic [VLW-1:0]               req_vl,
    input  logic [NELEM-1:0]             req_mask,
    input  logic [VLEN-1:0]              req_wdata,
    output logic [NLANES-1:0]            mem_re,
    output logic [NLANES-1:0]            mem_we,
    output logic [NLANES*ADDR_WIDTH-1:0] mem_addr,
    output logic [NLANES*ELEN-1:0]       mem_wdata,
    input  logic [NLANES*ELEN-1:0]       mem_rdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [VLEN-1:0]              rsp_rdata,
    output logic                         busy
);

    localparam int MW = (NELEM > 1) ? $clog2(NELEM) : 1;

    state_e             state, state_nxt;
    logic [VLW-1:0]     beat;
    logic [VLW-1:0]     nbeats;
    logic [VLW-1:0]     vl_in;
    logic               accept;

    // Latched request payload.
    logic               store_q;
    logic               strided_q;
    logic [XLEN-1:0]    base_q;
    logic [XLEN-1:0]    stride_q;
    logic [VLW-1:0]     vl_eff;
    logic [NELEM-1:0]   mask_q;
    logic [VLEN-1:0]    wdata_q;

    // Lane enables and the one-cycle-delayed read tracking for capture.
    logic [NLANES-1:0]  lane_en;
    logic [NLANES-1:0]  rd_en_q;
    logic [VLW-1:0]     rd_beat_q;

    assign accept    = req_valid && req_ready;
    assign vl_in     = (req_vl > VLW'(NELEM)) ? VLW'(NELEM) : req_vl;
    assign nbeats    = VLW'((int'(vl_eff) + NLANES - 1) / NLANES);

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_re    = (state == ISSUE && !store_q) ? lane_en : '0;
    assign mem_we    = (state == ISSUE &&  store_q) ? lane_en : '0;

    // Per-lane element index, mask lookup, address and store data.
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic [XLEN-1:0] elem;
        logic [MW-1:0]   eidx;
        logic            in_range;
        logic            mask_bit;

        assign elem     = XLEN'(beat) * XLEN'(NLANES) + XLEN'(l);
        assign eidx     = elem[MW-1:0];
        assign in_range = (elem < XLEN'(NELEM));
        assign mask_bit = in_range ? mask_q[eidx] : 1'b0;

        vlsu_addr_gen #(
            .XLEN       (XLEN),
            .ELEN       (ELEN),
            .ADDR_WIDTH (ADDR_WIDTH),
            .VLW        (VLW)
        ) u_addr_gen (
            .base     (base_q),
            .stride   (stride_q),
            .strided  (strided_q),
            .elem     (elem),
            .vl_eff   (vl_eff),
            .mask_bit (mask_bit),
            .addr     (mem_addr[l*ADDR_WIDTH +: ADDR_WIDTH]),
            .enable   (lane_en[l])
        );

        assign mem_wdata[l*ELEN +: ELEN] = in_range ? wdata_q[eidx*ELEN +: ELEN] : '0;
    end

    // Next-state logic for the request/issue/drain/response sequence.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (vl_in == '0) ? DRAIN : ISSUE;
            ISSUE:   if (beat == nbeats - 1'b1) state_nxt = DRAIN;
            DRAIN:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, beat counter and read-capture pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            rd_en_q   <= '0;
            rd_beat_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state     <= state_nxt;
            rd_en_q   <= mem_re;
            rd_beat_q <= beat;
            if (accept) begin
                beat <= '0;
            end else if (state == ISSUE) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Request payload capture on handshake.
    always_ff @(posedge clk) begin
        // NOTE: payload is only read after an accept loads it, so it needs no reset.
        if (accept) begin
            store_q   <= req_store;
            strided_q <= req_strided;
            base_q    <= req_base;
            stride_q  <= req_stride;
            vl_eff    <= vl_in;
            mask_q    <= req_mask;
            wdata_q   <= req_wdata;
        end
    end

    // Load result assembly: cleared on accept, filled the cycle after each beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
        end else if (accept) begin
            rsp_rdata <= '0;
        end else begin
            for (int l = 0; l < NLANES; l++) begin
                if (rd_en_q[l]) begin
                    rsp_rdata[(int'(rd_beat_q) * NLANES + l) * ELEN +: ELEN] <= mem_rdata[l*ELEN +: ELEN];
                end
            end
        end
    end

endmodule
